// File: rtl/mips32_pkg.sv
// mips32_pkg: opcodes, loader states and error codes shared by the core, the loader and the benches
package mips32_pkg;
  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_HLT  = 6'b111111;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_VERIFY, ST_RUN, ST_DONE} ld_state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_OVF, ERR_VERIFY, ERR_TMO} ld_err_t;
endpackage

// File: rtl/mips32_xor_acc.sv
// mips32_xor_acc: running XOR of accepted words with synchronous clear
module mips32_xor_acc #(
  parameter int DATA_W = 32
)(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_acc
);
  logic [DATA_W-1:0] r_acc;
  always_ff @(posedge i_clk)
    if (i_rst || i_clr) r_acc <= '0;
    else if (i_en) r_acc <= r_acc ^ i_data;
  assign o_acc = r_acc;
endmodule

// File: rtl/mips32_prog_loader.sv
// mips32_prog_loader: streams a program image into memory, XOR-verifies it by readback, then runs the core to HLT
module mips32_prog_loader
  import mips32_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int BASE_ADDR = 0,
  parameter int RUN_TMO   = 4096
)(
  input  logic              i_clk1,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [DATA_W-1:0] i_s_data,
  input  logic              i_s_last,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_cpu_run,
  input  logic              i_cpu_halted,
  output logic [ADDR_W:0]   o_word_count,
  output logic              o_done,
  output logic [1:0]        o_error
);
  localparam logic [ADDR_W:0]   W_CAP  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] W_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] W_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   W_ONE1 = (ADDR_W+1)'(1);
  ld_state_t         r_state, w_next;
  ld_err_t           r_error;
  logic              r_mem_we, r_cpu_run, r_done, r_v1, r_v2;
  logic [ADDR_W-1:0] r_mem_addr, r_wr_ptr;
  logic [DATA_W-1:0] r_mem_wdata, w_wr_xor, w_rd_xor;
  logic [ADDR_W:0]   r_word_count, r_rd_ptr, r_rd_cnt;
  logic [31:0]       r_run_cnt;
  logic w_start, w_accept, w_ovf, w_rd_issue, w_rd_cap, w_vfy_end, w_vfy_ok, w_halt, w_tmo;
  assign w_start    = i_start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign o_s_ready  = r_state == ST_LOAD && r_word_count != W_CAP;
  assign w_accept   = i_s_valid && o_s_ready;
  assign w_ovf      = r_state == ST_LOAD && i_s_valid && r_word_count == W_CAP;
  assign w_rd_issue = r_state == ST_VERIFY && r_rd_ptr != r_word_count;
  assign w_rd_cap   = r_state == ST_VERIFY && r_v2;
  // the read pipeline must drain before the checksums are final
  assign w_vfy_end  = r_state == ST_VERIFY && r_rd_ptr == r_word_count && !r_v1 && !r_v2;
  assign w_vfy_ok   = w_rd_xor == w_wr_xor && r_rd_cnt == r_word_count;
  assign w_halt     = r_state == ST_RUN && i_cpu_halted;
  assign w_tmo      = r_state == ST_RUN && RUN_TMO != 0 && r_run_cnt + 32'd1 == 32'(RUN_TMO);
  mips32_xor_acc #(.DATA_W(DATA_W)) u_wr_acc (
    .i_clk(i_clk1), .i_rst(i_rst), .i_clr(w_start), .i_en(w_accept),
    .i_data(i_s_data), .o_acc(w_wr_xor)
  );
  mips32_xor_acc #(.DATA_W(DATA_W)) u_rd_acc (
    .i_clk(i_clk1), .i_rst(i_rst), .i_clr(w_start), .i_en(w_rd_cap),
    .i_data(i_mem_rdata), .o_acc(w_rd_xor)
  );
  always_ff @(posedge i_clk1)
    if (i_rst) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: w_next = i_start ? ST_LOAD : r_state;
      ST_LOAD:          w_next = w_ovf ? ST_DONE : (w_accept && i_s_last) ? ST_VERIFY : ST_LOAD;
      ST_VERIFY:        w_next = !w_vfy_end ? ST_VERIFY : w_vfy_ok ? ST_RUN : ST_DONE;
      ST_RUN:           w_next = (w_halt || w_tmo) ? ST_DONE : ST_RUN;
      default:          w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge i_clk1)
    if (i_rst) begin
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_run    <= 1'b0;
      r_word_count <= '0;
      r_done       <= 1'b0;
      r_error      <= ERR_NONE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_rd_cnt     <= '0;
      r_v1         <= 1'b0;
      r_v2         <= 1'b0;
      r_run_cnt    <= '0;
    end else begin
      r_mem_we  <= w_accept;
      r_v1      <= w_rd_issue;
      r_v2      <= r_v1;
      r_run_cnt <= r_state == ST_RUN ? r_run_cnt + 32'd1 : '0;
      if (w_accept) begin
        r_mem_addr   <= W_BASE + r_wr_ptr;
        r_mem_wdata  <= i_s_data;
        r_wr_ptr     <= r_wr_ptr + W_ONE;
        r_word_count <= r_word_count + W_ONE1;
      end else if (w_rd_issue) begin
        r_mem_addr <= W_BASE + r_rd_ptr[ADDR_W-1:0];
        r_rd_ptr   <= r_rd_ptr + W_ONE1;
      end
      if (w_rd_cap) r_rd_cnt <= r_rd_cnt + W_ONE1;
      if (w_start) begin
        r_word_count <= '0;
        r_done       <= 1'b0;
        r_error      <= ERR_NONE;
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_rd_cnt     <= '0;
      end
      if (w_ovf) r_error <= ERR_OVF;
      if (w_vfy_end) begin
        r_cpu_run <= w_vfy_ok;
        if (!w_vfy_ok) r_error <= ERR_VERIFY;
      end
      if (w_halt) begin
        r_cpu_run <= 1'b0;
        r_done    <= 1'b1;
      end else if (w_tmo) begin
        r_cpu_run <= 1'b0;
        r_error   <= ERR_TMO;
      end
    end
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_cpu_run    = r_cpu_run;
  assign o_word_count = r_word_count;
  assign o_done       = r_done;
  assign o_error      = r_error;
endmodule

// File: tb/tb_mips32_prog_loader.sv
// tb_mips32_prog_loader: directed load/verify/run scenarios against a small memory and core model
module tb_mips32_prog_loader;
  import mips32_pkg::*;
  logic        clk = 0, rst = 1, start0 = 0, start1 = 0, sel = 0, flip2 = 0;
  logic        s_valid = 0, s_last = 0;
  logic [31:0] s_data = 0;
  logic        d_ready, d_we, d_run, d_done, halted = 0;
  logic [9:0]  d_addr, pc = 0;
  logic [31:0] d_wdata, d_rdata = 0;
  logic [10:0] d_wc;
  logic [1:0]  d_err;
  logic        o_ready, o_we, o_run, o_done;
  logic [2:0]  o_addr, o_last_addr = 0;
  logic [31:0] o_wdata, o_last_data = 0;
  logic [3:0]  o_wc;
  logic [1:0]  o_err;
  logic        w_ready;
  logic [31:0] mem [0:1023];
  logic [31:0] rf [0:31];
  logic [31:0] ins, ea;
  logic [9:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int run_n = 0, o_run_n = 0, o_wr_n = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign w_ready = sel ? o_ready : d_ready;
  mips32_prog_loader #(.ADDR_W(10), .DATA_W(32), .BASE_ADDR(0), .RUN_TMO(50)) u_dut (
    .i_clk1(clk), .i_rst(rst), .i_start(start0), .i_s_valid(s_valid && !sel), .o_s_ready(d_ready),
    .i_s_data(s_data), .i_s_last(s_last), .o_mem_we(d_we), .o_mem_addr(d_addr), .o_mem_wdata(d_wdata),
    .i_mem_rdata(d_rdata), .o_cpu_run(d_run), .i_cpu_halted(halted), .o_word_count(d_wc),
    .o_done(d_done), .o_error(d_err)
  );
  mips32_prog_loader #(.ADDR_W(3), .DATA_W(32), .BASE_ADDR(0), .RUN_TMO(50)) u_ovf (
    .i_clk1(clk), .i_rst(rst), .i_start(start1), .i_s_valid(s_valid && sel), .o_s_ready(o_ready),
    .i_s_data(s_data), .i_s_last(s_last), .o_mem_we(o_we), .o_mem_addr(o_addr), .o_mem_wdata(o_wdata),
    .i_mem_rdata(32'd0), .o_cpu_run(o_run), .i_cpu_halted(1'b0), .o_word_count(o_wc),
    .o_done(o_done), .o_error(o_err)
  );
  function automatic logic [31:0] rv(input logic [4:0] r);
    return r == 5'd0 ? 32'd0 : rf[r];
  endfunction
  assign ins = mem[pc];
  assign ea  = rv(ins[25:21]) + {{16{ins[15]}}, ins[15:0]};
  always @(posedge clk) begin
    if (d_we) begin
      mem[d_addr] <= d_wdata;
      wa_q.push_back(d_addr);
      wd_q.push_back(d_wdata);
    end
    d_rdata <= mem[d_addr] ^ {31'd0, flip2 && d_addr == 10'd2};
    if (o_we) begin
      o_wr_n      <= o_wr_n + 1;
      o_last_addr <= o_addr;
      o_last_data <= o_wdata;
    end
    if (o_run) o_run_n <= o_run_n + 1;
    if (d_run) run_n <= run_n + 1;
    if (!d_run) begin
      pc     <= 10'd0;
      halted <= 1'b0;
    end else if (!halted) begin
      pc <= pc + 10'd1;
      case (ins[31:26])
        OP_ADDI: if (ins[20:16] != 0) rf[ins[20:16]] <= ea;
        OP_ADD:  if (ins[15:11] != 0) rf[ins[15:11]] <= rv(ins[25:21]) + rv(ins[20:16]);
        OP_LW:   if (ins[20:16] != 0) rf[ins[20:16]] <= mem[ea[9:0]];
        OP_SW:   mem[ea[9:0]] <= rv(ins[20:16]);
        OP_HLT:  halted <= 1'b1;
        default: ;
      endcase
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ei(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] er(input logic [5:0] op, input int rs, input int rt, input int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction
  task automatic send(input logic [31:0] w, input logic l, input bit gap);
    int n = 0;
    @(negedge clk);
    s_valid = 1; s_data = w; s_last = l;
    while (!w_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_ready", {31'd0, w_ready}, 32'd1);
    @(posedge clk);
    if (gap) begin
      @(negedge clk);
      s_valid = 0;
    end
  endtask
  task automatic load(input logic [31:0] p[$], input bit gap, input bit last_ok);
    @(negedge clk);
    if (sel) start1 = 1; else start0 = 1;
    @(negedge clk);
    start0 = 0; start1 = 0;
    foreach (p[i]) send(p[i], last_ok && i == p.size() - 1, gap);
    @(negedge clk);
    s_valid = 0; s_last = 0;
  endtask
  task automatic wait_run();
    int n = 0;
    while (!d_run && d_err == 2'd0 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic wait_end();
    int n = 0;
    while (!d_done && d_err == 2'd0 && n < 500) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic chk_writes(input string tag, input int base, input logic [31:0] p[$]);
    chk({tag, "_nwr"}, 32'(wa_q.size() - base), 32'(p.size()));
    for (int i = 0; i < p.size() && base + i < wa_q.size(); i++) begin
      chk($sformatf("%s_wa%0d", tag, i), 32'(wa_q[base+i]), 32'(i));
      chk($sformatf("%s_wd%0d", tag, i), wd_q[base+i], p[i]);
    end
  endtask
  initial begin
    logic [31:0] ph[$], pn[$], p8[$];
    int base, rbase;
    ph = '{ei(OP_ADDI, 0, 1, 5), ei(OP_ADDI, 0, 2, 3), er(OP_ADD, 1, 2, 3),
           ei(OP_SW, 0, 3, 100), ei(OP_LW, 0, 4, 100), {OP_HLT, 26'd0}};
    for (int i = 0; i < 60; i++) pn.push_back(ei(OP_ADDI, 3, 3, 1));
    for (int i = 0; i < 8; i++) p8.push_back(32'hA000_0000 + 32'(i));
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, d_ready}, 32'd0);
    chk("rst_we", {31'd0, d_we}, 32'd0);
    chk("rst_addr", 32'(d_addr), 32'd0);
    chk("rst_wdata", d_wdata, 32'd0);
    chk("rst_run", {31'd0, d_run}, 32'd0);
    chk("rst_wc", 32'(d_wc), 32'd0);
    chk("rst_done", {31'd0, d_done}, 32'd0);
    chk("rst_err", 32'(d_err), 32'd0);
    rst = 0;
    base = wa_q.size();
    load(ph, 0, 1);
    wait_run();
    chk("t1_run", {31'd0, d_run}, 32'd1);
    chk("t1_wc", 32'(d_wc), 32'd6);
    chk_writes("t1", base, ph);
    wait_end();
    chk("t1_done", {31'd0, d_done}, 32'd1);
    chk("t1_err", 32'(d_err), 32'd0);
    chk("t1_r1", rf[1], 32'd5);
    chk("t1_r2", rf[2], 32'd3);
    chk("t1_r3", rf[3], 32'd8);
    chk("t1_r4", rf[4], 32'd8);
    chk("t1_m100", mem[100], 32'd8);
    @(negedge clk);
    chk("t1_run_off", {31'd0, d_run}, 32'd0);
    base = wa_q.size();
    load(ph, 1, 1);
    wait_end();
    chk_writes("t2", base, ph);
    chk("t2_wc", 32'(d_wc), 32'd6);
    chk("t2_done", {31'd0, d_done}, 32'd1);
    chk("t2_err", 32'(d_err), 32'd0);
    sel = 1;
    load(p8, 0, 0);
    @(negedge clk);
    s_valid = 1; s_data = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    s_valid = 0;
    chk("t3_nwr", 32'(o_wr_n), 32'd8);
    chk("t3_lastaddr", 32'(o_last_addr), 32'd7);
    chk("t3_lastdata", o_last_data, 32'hA000_0007);
    chk("t3_wc", 32'(o_wc), 32'd8);
    chk("t3_err", 32'(o_err), 32'd1);
    chk("t3_run", 32'(o_run_n), 32'd0);
    chk("t3_done", {31'd0, o_done}, 32'd0);
    sel = 0;
    flip2 = 1;
    rbase = run_n;
    load(ph, 0, 1);
    wait_end();
    flip2 = 0;
    chk("t4_err", 32'(d_err), 32'd2);
    chk("t4_done", {31'd0, d_done}, 32'd0);
    chk("t4_run", 32'(run_n - rbase), 32'd0);
    rbase = run_n;
    load(pn, 0, 1);
    wait_run();
    chk("t5_run", {31'd0, d_run}, 32'd1);
    wait_end();
    @(negedge clk);
    chk("t5_cycles", 32'(run_n - rbase), 32'd50);
    chk("t5_err", 32'(d_err), 32'd3);
    chk("t5_done", {31'd0, d_done}, 32'd0);
    chk("t5_run_off", {31'd0, d_run}, 32'd0);
    load(pn, 0, 1);
    wait_run();
    chk("t6_run", {31'd0, d_run}, 32'd1);
    repeat (10) @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    chk("t6_rst_run", {31'd0, d_run}, 32'd0);
    chk("t6_rst_we", {31'd0, d_we}, 32'd0);
    chk("t6_rst_wc", 32'(d_wc), 32'd0);
    chk("t6_rst_ready", {31'd0, d_ready}, 32'd0);
    @(negedge clk);
    rst = 0;
    load(ph, 0, 1);
    wait_end();
    chk("t6_done", {31'd0, d_done}, 32'd1);
    chk("t6_err", 32'(d_err), 32'd0);
    chk("t6_r3", rf[3], 32'd8);
    chk("t6_wc", 32'(d_wc), 32'd6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
